// File: rtl/round_judge.sv
// round_judge: collects one card code from each player, checks legality against
// per-player used-card masks, decides the round and keeps scores and round count.
// Ports:
//   clk, resetn                       clock, synchronous active-low reset
//   p1_handcard/p1_valid              player 1 code (0..8 legal) and strobe
//   p2_handcard/p2_valid              player 2 code and strobe
//   result/result_valid               00 none, 01 p1, 10 p2, 11 draw; 1-cycle pulse
//   illegal_p1/illegal_p2             last judged card illegal, held to next judgement
//   p1_score/p2_score/round           rounds won per player, rounds judged (0..9)
//   p1_used/p2_used                   one-hot masks of legally played cards
//   game_over                         high once nine rounds are judged
module round_judge (
   input  logic       clk,
   input  logic       resetn,
   input  logic [3:0] p1_handcard,
   input  logic       p1_valid,
   input  logic [3:0] p2_handcard,
   input  logic       p2_valid,
   output logic [1:0] result,
   output logic       result_valid,
   output logic       illegal_p1,
   output logic       illegal_p2,
   output logic [3:0] p1_score,
   output logic [3:0] p2_score,
   output logic [3:0] round,
   output logic [8:0] p1_used,
   output logic [8:0] p2_used,
   output logic       game_over
);

   localparam int unsigned CODE_W  = 4;
   localparam int unsigned CARDS   = 9;
   localparam int unsigned COUNT_W = 4;

   localparam logic [1:0] RES_P1   = 2'b01;
   localparam logic [1:0] RES_P2   = 2'b10;
   localparam logic [1:0] RES_DRAW = 2'b11;

   typedef enum logic [1:0] {S_WAIT, S_JUDGE, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [CODE_W-1:0]   p1_code_q, p1_code_d, p2_code_q, p2_code_d;
   logic                p1_got_q, p1_got_d, p2_got_q, p2_got_d;
   logic [1:0]          result_q, result_d;
   logic                result_valid_q, result_valid_d;
   logic                illegal_p1_q, illegal_p1_d, illegal_p2_q, illegal_p2_d;
   logic [COUNT_W-1:0]  p1_score_q, p1_score_d, p2_score_q, p2_score_d;
   logic [COUNT_W-1:0]  round_q, round_d;
   logic [CARDS-1:0]    p1_used_q, p1_used_d, p2_used_q, p2_used_d;
   logic                game_over_q, game_over_d;

   logic [CARDS-1:0]    p1_oh_c, p2_oh_c;
   logic                p1_legal_c, p2_legal_c;
   logic [1:0]          verdict_c;

   // Decode latched codes and judge; out-of-range codes decode to no bit.
   always_comb begin
      p1_oh_c    = '0;
      p2_oh_c    = '0;
      p1_legal_c = 1'b0;
      p2_legal_c = 1'b0;
      verdict_c  = RES_DRAW;
      if (p1_code_q < CODE_W'(CARDS)) begin
         p1_oh_c    = CARDS'(1) << p1_code_q;
         p1_legal_c = ~|(p1_oh_c & p1_used_q);
      end
      if (p2_code_q < CODE_W'(CARDS)) begin
         p2_oh_c    = CARDS'(1) << p2_code_q;
         p2_legal_c = ~|(p2_oh_c & p2_used_q);
      end
      if (!p1_legal_c && !p2_legal_c) begin
         verdict_c = RES_DRAW;
      end else if (!p1_legal_c) begin
         verdict_c = RES_P2;
      end else if (!p2_legal_c) begin
         verdict_c = RES_P1;
      end else if (p1_code_q == p2_code_q) begin
         verdict_c = RES_DRAW;
      end else if (p1_code_q == CODE_W'(0) && p2_code_q == CODE_W'(CARDS - 1)) begin
         verdict_c = RES_P1;   // card 1 beats card 9
      end else if (p2_code_q == CODE_W'(0) && p1_code_q == CODE_W'(CARDS - 1)) begin
         verdict_c = RES_P2;
      end else begin
         verdict_c = (p1_code_q > p2_code_q) ? RES_P1 : RES_P2;
      end
   end

   // Next-state and output logic.
   always_comb begin
      state_d        = state_q;
      p1_code_d      = p1_code_q;
      p2_code_d      = p2_code_q;
      p1_got_d       = p1_got_q;
      p2_got_d       = p2_got_q;
      result_d       = result_q;
      result_valid_d = 1'b0;
      illegal_p1_d   = illegal_p1_q;
      illegal_p2_d   = illegal_p2_q;
      p1_score_d     = p1_score_q;
      p2_score_d     = p2_score_q;
      round_d        = round_q;
      p1_used_d      = p1_used_q;
      p2_used_d      = p2_used_q;
      game_over_d    = game_over_q;

      case (state_q)
         S_WAIT: begin
            // First strobe per player wins; repeats are ignored.
            if (p1_valid && !p1_got_q) begin
               p1_got_d  = 1'b1;
               p1_code_d = p1_handcard;
            end
            if (p2_valid && !p2_got_q) begin
               p2_got_d  = 1'b1;
               p2_code_d = p2_handcard;
            end
            if (p1_got_d && p2_got_d) begin
               state_d = S_JUDGE;
            end
         end
         S_JUDGE: begin
            result_d       = verdict_c;
            result_valid_d = 1'b1;
            illegal_p1_d   = !p1_legal_c;
            illegal_p2_d   = !p2_legal_c;
            if (p1_legal_c) p1_used_d = p1_used_q | p1_oh_c;
            if (p2_legal_c) p2_used_d = p2_used_q | p2_oh_c;
            if (verdict_c == RES_P1) p1_score_d = p1_score_q + COUNT_W'(1);
            if (verdict_c == RES_P2) p2_score_d = p2_score_q + COUNT_W'(1);
            round_d  = round_q + COUNT_W'(1);
            p1_got_d = 1'b0;
            p2_got_d = 1'b0;
            if (round_d == COUNT_W'(CARDS)) begin
               state_d     = S_DONE;
               game_over_d = 1'b1;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_DONE: begin
            state_d = S_DONE;
         end
         default: begin
            state_d = S_WAIT;
         end
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q        <= S_WAIT;
         p1_code_q      <= '0;
         p2_code_q      <= '0;
         p1_got_q       <= 1'b0;
         p2_got_q       <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         illegal_p1_q   <= 1'b0;
         illegal_p2_q   <= 1'b0;
         p1_score_q     <= '0;
         p2_score_q     <= '0;
         round_q        <= '0;
         p1_used_q      <= '0;
         p2_used_q      <= '0;
         game_over_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         p1_code_q      <= p1_code_d;
         p2_code_q      <= p2_code_d;
         p1_got_q       <= p1_got_d;
         p2_got_q       <= p2_got_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         illegal_p1_q   <= illegal_p1_d;
         illegal_p2_q   <= illegal_p2_d;
         p1_score_q     <= p1_score_d;
         p2_score_q     <= p2_score_d;
         round_q        <= round_d;
         p1_used_q      <= p1_used_d;
         p2_used_q      <= p2_used_d;
         game_over_q    <= game_over_d;
      end
   end

   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign illegal_p1   = illegal_p1_q;
   assign illegal_p2   = illegal_p2_q;
   assign p1_score     = p1_score_q;
   assign p2_score     = p2_score_q;
   assign round        = round_q;
   assign p1_used      = p1_used_q;
   assign p2_used      = p2_used_q;
   assign game_over    = game_over_q;

endmodule

// File: tb/tb_round_judge.sv
// Testbench for round_judge: directed table, hand-written corner sequences and
// randomized games checked against a card-value reference model.
module tb_round_judge;

   logic       clk = 1'b0;
   logic       resetn = 1'b1;
   logic [3:0] p1_handcard = '0;
   logic       p1_valid = 1'b0;
   logic [3:0] p2_handcard = '0;
   logic       p2_valid = 1'b0;
   logic [1:0] result;
   logic       result_valid;
   logic       illegal_p1, illegal_p2;
   logic [3:0] p1_score, p2_score, round;
   logic [8:0] p1_used, p2_used;
   logic       game_over;

   round_judge dut (
      .clk(clk), .resetn(resetn),
      .p1_handcard(p1_handcard), .p1_valid(p1_valid),
      .p2_handcard(p2_handcard), .p2_valid(p2_valid),
      .result(result), .result_valid(result_valid),
      .illegal_p1(illegal_p1), .illegal_p2(illegal_p2),
      .p1_score(p1_score), .p2_score(p2_score), .round(round),
      .p1_used(p1_used), .p2_used(p2_used), .game_over(game_over)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: cards as values 1..9, used cards as flag arrays.
   bit   mu1 [9];
   bit   mu2 [9];
   int   ms1, ms2, mround;
   int   mres;
   bit   mil1, mil2;

   typedef struct {
      bit         rst;
      logic [3:0] c1;
      logic [3:0] c2;
      int         gap;
      bit         p2first;
      logic [1:0] exp_res;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [8:0] mask_of(input bit u [9]);
      logic [8:0] m = '0;
      for (int i = 0; i < 9; i++) m[i] = u[i];
      return m;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 9; i++) begin mu1[i] = 1'b0; mu2[i] = 1'b0; end
      ms1 = 0; ms2 = 0; mround = 0; mres = 0; mil1 = 1'b0; mil2 = 1'b0;
   endtask

   task automatic model_judge(input int c1, input int c2);
      bit l1 = 1'b0, l2 = 1'b0;
      int v1 = c1 + 1, v2 = c2 + 1;
      if (c1 <= 8) l1 = !mu1[c1];
      if (c2 <= 8) l2 = !mu2[c2];
      if (!l1 && !l2)               mres = 3;
      else if (!l1)                 mres = 2;
      else if (!l2)                 mres = 1;
      else if (v1 == v2)            mres = 3;
      else if (v1 == 1 && v2 == 9)  mres = 1;
      else if (v2 == 1 && v1 == 9)  mres = 2;
      else                          mres = (v1 > v2) ? 1 : 2;
      if (l1) mu1[c1] = 1'b1;
      if (l2) mu2[c2] = 1'b1;
      if (mres == 1) ms1++;
      if (mres == 2) ms2++;
      mil1 = !l1; mil2 = !l2;
      mround++;
   endtask

   task automatic compare_all(input string tag);
      chk({tag, "_result"}, int'(result), mres);
      chk({tag, "_ill1"}, int'(illegal_p1), int'(mil1));
      chk({tag, "_ill2"}, int'(illegal_p2), int'(mil2));
      chk({tag, "_s1"}, int'(p1_score), ms1);
      chk({tag, "_s2"}, int'(p2_score), ms2);
      chk({tag, "_round"}, int'(round), mround);
      chk({tag, "_used1"}, int'(p1_used), int'(mask_of(mu1)));
      chk({tag, "_used2"}, int'(p2_used), int'(mask_of(mu2)));
      chk({tag, "_gover"}, int'(game_over), (mround == 9) ? 1 : 0);
   endtask

   // Called at a negedge; applies one cycle of strobes, returns at next negedge.
   task automatic drive(input bit v1, input logic [3:0] c1, input bit v2, input logic [3:0] c2);
      p1_valid = v1; p1_handcard = c1; p2_valid = v2; p2_handcard = c2;
      @(negedge clk);
      p1_valid = 1'b0; p2_valid = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      for (int i = 0; i < 2; i++) begin
         p1_valid = 1'($urandom); p1_handcard = 4'($urandom);
         p2_valid = 1'($urandom); p2_handcard = 4'($urandom);
         @(negedge clk);
      end
      resetn = 1'b1; p1_valid = 1'b0; p2_valid = 1'b0;
      model_reset();
      chk("rst_rv", int'(result_valid), 0);
      compare_all("rst");
   endtask

   // Wait for the judgement pulse right after the JUDGE cycle, check, then check it drops.
   task automatic collect(input string tag);
      bit seen = 1'b0;
      int lat = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (result_valid) begin seen = 1'b1; lat = k; break; end
      end
      if (!seen) begin
         chk({tag, "_rv_timeout"}, 0, 1);
      end else begin
         chk({tag, "_latency"}, lat, 1);
         compare_all(tag);
         @(negedge clk);
         chk({tag, "_rv_drop"}, int'(result_valid), 0);
      end
   endtask

   task automatic play(input logic [3:0] c1, input logic [3:0] c2, input int gap,
                       input bit p2first, input string tag);
      if (gap == 0) begin
         drive(1'b1, c1, 1'b1, c2);
      end else begin
         if (p2first) drive(1'b0, 4'd0, 1'b1, c2); else drive(1'b1, c1, 1'b0, 4'd0);
         repeat (gap - 1) @(negedge clk);
         if (p2first) drive(1'b1, c1, 1'b0, 4'd0); else drive(1'b0, 4'd0, 1'b1, c2);
      end
      model_judge(int'(c1), int'(c2));
      collect(tag);
   endtask

   logic [3:0] p1_rest [7];
   logic [3:0] p2_rest [7];

   initial begin
      vecs[0] = '{1'b1, 4'd6,  4'd2,  0, 1'b0, 2'b01};
      vecs[1] = '{1'b0, 4'd0,  4'd8,  4, 1'b1, 2'b01};
      vecs[2] = '{1'b0, 4'd6,  4'd1,  1, 1'b0, 2'b10};
      vecs[3] = '{1'b0, 4'd12, 4'd12, 0, 1'b0, 2'b11};
      vecs[4] = '{1'b0, 4'd3,  4'd3,  2, 1'b1, 2'b11};
      vecs[5] = '{1'b1, 4'd7,  4'd8,  0, 1'b0, 2'b10};
      vecs[6] = '{1'b0, 4'd8,  4'd0,  1, 1'b1, 2'b10};
      vecs[7] = '{1'b0, 4'd1,  4'd9,  0, 1'b0, 2'b01};
      p1_rest = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd7, 4'd8};
      p2_rest = '{4'd8, 4'd0, 4'd1, 4'd3, 4'd5, 4'd6, 4'd7};

      model_reset();
      @(negedge clk);

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].rst) do_reset();
         play(vecs[i].c1, vecs[i].c2, vecs[i].gap, vecs[i].p2first, $sformatf("vec%0d", i));
         chk($sformatf("vec%0d_tbl_res", i), int'(result), int'(vecs[i].exp_res));
         if (i == 0) begin
            chk("vec0_used1", int'(p1_used), 9'h040);
            chk("vec0_used2", int'(p2_used), 9'h004);
         end
         if (i == 2) chk("vec2_used1_kept", int'(p1_used), 9'h041);
      end

      // Repeated p1 strobes: first code (3) is kept.
      do_reset();
      drive(1'b1, 4'd3, 1'b0, 4'd0);
      drive(1'b1, 4'd5, 1'b0, 4'd0);
      drive(1'b0, 4'd0, 1'b1, 4'd4);
      model_judge(3, 4);
      collect("ignore");
      chk("ignore_tbl_res", int'(result), 2);

      // Strobes in the JUDGE cycle are dropped.
      drive(1'b1, 4'd6, 1'b1, 4'd2);
      model_judge(6, 2);
      drive(1'b1, 4'd5, 1'b1, 4'd5);
      chk("jdrop_rv", int'(result_valid), 1);
      compare_all("jdrop");
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("jdrop_no_judge", int'(result_valid), 0);
      end
      chk("jdrop_round", int'(round), 2);

      // Finish the game with legal cards.
      for (int i = 0; i < 7; i++) play(p1_rest[i], p2_rest[i], i % 3, 1'($urandom), $sformatf("full%0d", i));
      chk("full_gover", int'(game_over), 1);
      chk("full_round", int'(round), 9);

      // DONE ignores strobes.
      drive(1'b1, 4'd2, 1'b1, 4'd3);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("done_no_rv", int'(result_valid), 0);
      end
      compare_all("done");

      // Reset discards a half-latched p1 card.
      drive(1'b1, 4'd4, 1'b0, 4'd0);
      do_reset();
      drive(1'b0, 4'd0, 1'b1, 4'd5);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("half_no_rv", int'(result_valid), 0);
      end
      chk("half_round", int'(round), 0);
      drive(1'b1, 4'd7, 1'b0, 4'd0);
      model_judge(7, 5);
      collect("half");

      // Randomized games against the model.
      for (int g = 0; g < 3; g++) begin
         do_reset();
         for (int r = 0; r < 9; r++) begin
            play(4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
                 int'($urandom_range(0, 3)), 1'($urandom), $sformatf("rnd%0d_%0d", g, r));
         end
         chk("rnd_gover", int'(game_over), 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/round_judge.md
# round_judge

Receiving end of the card handout path. Two `handout` instances each deliver a 4-bit `handcard` code for the card a player plays. `round_judge` collects both codes, decodes them to one-hot, checks legality against its own per-player used-card masks, and decides the round. It keeps scores and the round count, and flags game over after nine judged rounds. It sits between the two players' handout blocks and the score/display logic.

## Interface

Parameters: none. Card count is fixed at 9 and codes are fixed at 4 bits.

Ports (clock and reset first):
- `clk` input 1: system clock; all state updates on the rising edge.
- `resetn` input 1: reset, synchronous, active-low.
- `p1_handcard` input 4: player 1 card code; code k means card value k+1, legal range 0..8.
- `p1_valid` input 1: one-cycle strobe; `p1_handcard` is valid this cycle.
- `p2_handcard` input 4: player 2 card code, same encoding as `p1_handcard`.
- `p2_valid` input 1: one-cycle strobe for player 2.
- `result` output 2: outcome of the last judged round; 00 none, 01 p1 wins, 10 p2 wins, 11 draw.
- `result_valid` output 1: one-cycle pulse when `result` and the scores update.
- `illegal_p1` output 1: player 1's card in the last round was illegal. Held until the next judgement.
- `illegal_p2` output 1: same as `illegal_p1`, for player 2.
- `p1_score` output 4: player 1 rounds won, 0..9.
- `p2_score` output 4: player 2 rounds won, 0..9.
- `round` output 4: rounds judged so far, 0..9.
- `p1_used` output 9: one-hot accumulated mask of player 1 cards played legally.
- `p2_used` output 9: same as `p1_used`, for player 2.
- `game_over` output 1: high once `round` reaches 9.

## Operation

States:
- **WAIT**: collects player codes.
  - A `pN_valid` strobe while player N is not yet latched stores `pN_handcard` and sets `pN_got`.
  - A strobe while player N is already latched is ignored, and the first code is kept.
  - Both strobes may arrive in the same cycle; both are latched.
  - When both `pN_got` bits would be set after the edge, the next state is JUDGE.
- **JUDGE**: one cycle, no input sampling; all strobes in this cycle are ignored.
  - At the edge leaving JUDGE: `result`, scores, illegal flags, used masks and `round` update, and `result_valid` goes to 1.
  - Both `got` flags clear.
  - Next state is DONE if the new `round` equals 9, otherwise WAIT.
- **DONE**: all strobes are ignored, `game_over` is 1, and all outputs hold until `resetn`.

Legality, per player:
- A code is illegal if it is greater than 8, or if its decoded bit is already set in that player's used mask.
- Illegal cards are not added to the used mask.

Decision:
- Both illegal: draw (11); neither score changes.
- One illegal: the other player wins.
- Both legal:
  - Equal codes: draw (11).
  - Code 0 (card 1) against code 8 (card 9): code 0 wins.
  - Otherwise the higher code wins.
- The winner's score increments by 1. A draw changes no score.
- `round` increments on every judgement, draws and illegal rounds included.

## Timing

- Reset: when `resetn` is 0 at a rising edge, the next state is:
  - `result` = 00, `result_valid` = 0, both illegal flags = 0.
  - Both scores, `round`, both used masks = 0.
  - `game_over` = 0, both `got` flags cleared, state = WAIT.
- Reset overrides everything, including mid-round. A half-latched round is discarded.
- Latency: when the second strobe is sampled at edge E, the state is JUDGE after E.
  - At E+1, outputs update and `result_valid` = 1.
  - At E+2, `result_valid` = 0.
- Back-to-back: a strobe sampled at E+1 (the JUDGE cycle) is lost. Strobes are accepted again from edge E+2.
- Between judgements, `result`, the illegal flags and the scores are stable.
- Width rules:
  - Scores and `round` cannot exceed 9, so there is no wrap.
  - Codes 9..15 never set a used-mask bit.

## Test plan

- Reset: assert `resetn` = 0 for 2 cycles with random strobes -> every output is 0, state is WAIT.
- Same-cycle play: p1 code 6 and p2 code 2, strobed together at edge E -> at E+1 `result` = 01, `p1_score` = 1, `round` = 1, `p1_used` = 9'h040, `p2_used` = 9'h004; `result_valid` high for exactly one cycle.
- Special rule with staggered strobes: p2 code 8 at cycle 3, then p1 code 0 at cycle 7 -> `result` = 01. A further case: p1 code 7 against p2 code 8 -> `result` = 10.
- Illegal replay: p1 replays a used code 6 against p2 code 1 -> `illegal_p1` = 1, `result` = 10, `p2_score` increments, `p1_used` unchanged. A further case: p1 code 12 against p2 code 12 -> both flags set, `result` = 11, no score change.
- Ignored strobes: p1 strobes code 3 and then code 5 before p2 strobes code 4 -> the judgement uses code 3 and the result is 10. A strobe in the JUDGE cycle is dropped.
- Full game and reset: play nine legal rounds -> `game_over` = 1 and `round` = 9; later strobes change nothing. Then drive `resetn` = 0 after a lone p1 strobe -> all outputs return to 0, and the next round needs two fresh strobes.
